// File: rtl/branch_predictor_if.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor_if
// Brief    : Fetch/Execute bus between the pipeline and the branch predictor.
//            The pipeline side is the master; the predictor is the slave.
// Revision : 1.0  initial release
// ============================================================================
interface branch_predictor_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  // Fetch side
  logic [XLEN-1:0]  PCF;
  logic             predTakenF;
  logic [XLEN-1:0]  predTargetF;

  // Execute side
  logic             ctrlE;
  logic             stallE;
  logic [2:0]       branchE;
  logic [1:0]       jumpE;
  logic [1:0]       PCSrcE;
  logic [XLEN-1:0]  PCE;
  logic [XLEN-1:0]  PCPlus4E;
  logic [XLEN-1:0]  PCTargetE;
  logic             predTakenE;
  logic [XLEN-1:0]  predTargetE;
  logic             mispredictE;
  logic [XLEN-1:0]  redirectPCE;

  // Performance counters
  logic [CNT_W-1:0] branchCount;
  logic [CNT_W-1:0] mispredCount;

  modport master (
    output PCF, ctrlE, stallE, branchE, jumpE, PCSrcE, PCE, PCPlus4E,
           PCTargetE, predTakenE, predTargetE,
    input  predTakenF, predTargetF, mispredictE, redirectPCE,
           branchCount, mispredCount
  );

  modport slave (
    input  PCF, ctrlE, stallE, branchE, jumpE, PCSrcE, PCE, PCPlus4E,
           PCTargetE, predTakenE, predTargetE,
    output predTakenF, predTargetF, mispredictE, redirectPCE,
           branchCount, mispredCount
  );
endinterface
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor
// Brief    : Direct-mapped BTB branch predictor. Predicts next PC in Fetch,
//            resolves in Execute (mispredict + redirect PC), and keeps
//            saturating resolved/mispredict performance counters.
// Revision : 1.0  initial release
// ============================================================================
module branch_predictor #(
  parameter int ENTRIES  = 16,
  parameter int IDX_BITS = 4,
  parameter int XLEN     = 32,
  parameter int CNT_W    = 16
) (
  input wire               clk,
  input wire               rst,   // asynchronous, active-low
  branch_predictor_if.slave bp
);

  localparam int TAG_W = XLEN - IDX_BITS - 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [1:0] JUMP_JAL  = 2'b01;
  localparam logic [1:0] JUMP_JALR = 2'b10;

  // BTB storage
  logic             valid_q  [ENTRIES];
  logic             valid_d  [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];
  logic [1:0]       ctr_d    [ENTRIES];
  logic             jmp_q    [ENTRIES];
  logic             jmp_d    [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [TAG_W-1:0] tag_d    [ENTRIES];
  logic [XLEN-1:0]  target_q [ENTRIES];
  logic [XLEN-1:0]  target_d [ENTRIES];

  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  // Fetch-side lookup
  logic [IDX_BITS-1:0] f_idx;
  logic [TAG_W-1:0]    f_tag;
  logic                f_hit;
  logic                pred_taken_f;
  logic [XLEN-1:0]     pred_target_f;

  // Execute-side resolution
  logic [IDX_BITS-1:0] e_idx;
  logic [TAG_W-1:0]    e_tag;
  logic                e_hit;
  logic                upd_en;
  logic                actual_taken;
  logic                mispredict;
  logic                is_jal;
  logic                is_jalr;
  logic                is_branch;

  // Low PC bits are always zero for word-aligned instructions.
  logic unused_bits;
  assign unused_bits = &{1'b0, bp.PCF[1:0], bp.PCE[1:0]};

  assign f_idx = bp.PCF[IDX_BITS+1:2];
  assign f_tag = bp.PCF[XLEN-1:IDX_BITS+2];
  assign e_idx = bp.PCE[IDX_BITS+1:2];
  assign e_tag = bp.PCE[XLEN-1:IDX_BITS+2];

  // Zero-latency prediction from pre-edge BTB contents (no E->F bypass)
  always_comb begin
    f_hit         = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    pred_taken_f  = f_hit && (jmp_q[f_idx] || ctr_q[f_idx][1]);
    pred_target_f = pred_taken_f ? target_q[f_idx] : '0;
  end

  // Execute resolution: compare carried prediction against actual outcome
  always_comb begin
    upd_en       = bp.ctrlE && !bp.stallE;
    actual_taken = (bp.PCSrcE != 2'b00);
    is_jal       = (bp.jumpE == JUMP_JAL);
    is_jalr      = (bp.jumpE == JUMP_JALR);
    is_branch    = (bp.jumpE == 2'b00) && (bp.branchE != 3'b000);
    e_hit        = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
    mispredict   = upd_en &&
                   ((actual_taken != bp.predTakenE) ||
                    (actual_taken && (bp.predTargetE != bp.PCTargetE)));
  end

  assign bp.predTakenF   = pred_taken_f;
  assign bp.predTargetF  = pred_target_f;
  assign bp.mispredictE  = mispredict;
  assign bp.redirectPCE  = actual_taken ? bp.PCTargetE : bp.PCPlus4E;
  assign bp.branchCount  = branch_cnt_q;
  assign bp.mispredCount = mispred_cnt_q;

  // Next BTB state: only the entry addressed by PCE can change
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      valid_d[i]  = valid_q[i];
      ctr_d[i]    = ctr_q[i];
      jmp_d[i]    = jmp_q[i];
      tag_d[i]    = tag_q[i];
      target_d[i] = target_q[i];
    end
    // JALR targets are register-dependent, so they are never cached.
    if (upd_en && !is_jalr) begin
      if (is_jal) begin
        valid_d[e_idx]  = 1'b1;
        jmp_d[e_idx]    = 1'b1;
        ctr_d[e_idx]    = 2'b11;
        tag_d[e_idx]    = e_tag;
        target_d[e_idx] = bp.PCTargetE;
      end else if (is_branch) begin
        if (e_hit) begin
          if (actual_taken) begin
            if (ctr_q[e_idx] != 2'b11) ctr_d[e_idx] = ctr_q[e_idx] + 2'b01;
            target_d[e_idx] = bp.PCTargetE;
          end else begin
            if (ctr_q[e_idx] != 2'b00) ctr_d[e_idx] = ctr_q[e_idx] - 2'b01;
          end
        end else if (actual_taken) begin
          // Taken miss evicts whatever lives at this index.
          valid_d[e_idx]  = 1'b1;
          jmp_d[e_idx]    = 1'b0;
          ctr_d[e_idx]    = 2'b10;
          tag_d[e_idx]    = e_tag;
          target_d[e_idx] = bp.PCTargetE;
        end
      end
    end
  end

  // Saturating performance counters
  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (upd_en && (branch_cnt_q != CNT_MAX)) branch_cnt_d = branch_cnt_q + 1'b1;
    if (mispredict && (mispred_cnt_q != CNT_MAX)) mispred_cnt_d = mispred_cnt_q + 1'b1;
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        ctr_q[i]    <= 2'b01;
        jmp_q[i]    <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= valid_d[i];
        ctr_q[i]    <= ctr_d[i];
        jmp_q[i]    <= jmp_d[i];
        tag_q[i]    <= tag_d[i];
        target_q[i] <= target_d[i];
      end
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-stage dynamic branch predictor for the 5-stage RISC-V pipeline, with Execute-stage resolution and recovery.
- Direct-mapped BTB; each entry holds a 2-bit saturating counter, a tag, a target and a jump flag.
- Predicts next PC in F. In E, compares the prediction with the actual PCSrcE from the branch controller, raises a mispredict and supplies the redirect PC.
- Keeps saturating performance counters for control instructions resolved and mispredicts.

Parameters:
- ENTRIES, 16, number of BTB entries; power of two, at least 2.
- IDX_BITS, 4, log2(ENTRIES); index is PC[IDX_BITS+1:2].
- XLEN, 32, address width.
- CNT_W, 16, performance counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- PCF  in  XLEN  fetch PC.
- predTakenF  out  1  prediction that the fetched instruction redirects.
- predTargetF  out  XLEN  predicted target; equals 0 when predTakenF=0.
- ctrlE  in  1  E holds a branch, JAL or JALR (valid instruction).
- stallE  in  1  E stage frozen; blocks all state updates.
- branchE  in  3  branch type: 000 = jump/none, 001 = BEQ, 010 = BNE.
- jumpE  in  2  01 = JAL, 10 = JALR.
- PCSrcE  in  2  actual outcome from the branch controller; 00 = not taken.
- PCE  in  XLEN  PC of the E instruction.
- PCPlus4E  in  XLEN  fall-through PC.
- PCTargetE  in  XLEN  resolved target.
- predTakenE  in  1  predTakenF carried down the pipeline to E.
- predTargetE  in  XLEN  predTargetF carried down the pipeline to E.
- mispredictE  out  1  flush F/D and redirect the PC.
- redirectPCE  out  XLEN  correct next PC, valid when mispredictE=1.
- branchCount  out  CNT_W  control instructions resolved.
- mispredCount  out  CNT_W  mispredicts.

Behaviour:
- Reset (rst=0, asynchronous): all entries get valid=0, ctr=01, jmp=0, tag=0, target=0. Both performance counters are cleared. Outputs settle to predTakenF=0 and mispredictE=0.
- Prediction (combinational, 0-cycle):
  - idx = PCF[IDX_BITS+1:2]; hit = valid[idx] and tag[idx] == PCF[XLEN-1:IDX_BITS+2].
  - predTakenF = hit and (jmp[idx] or ctr[idx][1]).
  - predTargetF = target[idx] when predTakenF=1, else 0.
- Resolution (combinational):
  - actualTaken = (PCSrcE != 00).
  - mispredictE = ctrlE and not stallE and (actualTaken != predTakenE or (actualTaken and predTargetE != PCTargetE)).
  - redirectPCE = PCTargetE when actualTaken, else PCPlus4E.
- Update (at the clock edge, only when ctrlE=1 and stallE=0; the E-side entry is indexed by PCE):
  - JALR (jumpE=10): never allocated and never updated. It mispredicts whenever predTakenE=0.
  - BTB hit on a branch: ctr saturating-increments if taken (max 11), saturating-decrements if not taken (min 00). If taken, target is rewritten with PCTargetE.
  - BTB miss, taken branch: allocate with valid=1, tag from PCE, target=PCTargetE, ctr=10, jmp=0. This overwrites any existing entry at that index.
  - BTB miss, not-taken branch: no state change.
  - JAL: allocate or refresh with valid=1, jmp=1, ctr=11, target=PCTargetE.
- Performance counters: branchCount increments on every update cycle; mispredCount increments when mispredictE=1. Both saturate at all-ones and do not wrap.
- Same-index read in F and write in E in the same cycle: F sees the pre-edge contents (no bypass).
- stallE=1 holds all state and forces mispredictE=0; the redirect is issued on the cycle E unstalls.
- Reset asserted mid-operation clears state immediately; there are no pending updates.

Test Plan:
- Reset, then PCF=0x100 → predTakenF=0, predTargetF=0; branchCount=0, mispredCount=0.
- BEQ at PCE=0x100, taken to 0x140, predTakenE=0 → mispredictE=1, redirectPCE=0x140. Next cycle, PCF=0x100 → predTakenF=1, predTargetF=0x140, counter value 10.
- Same BEQ not taken twice with predTakenE matching the current prediction:
  - first resolution → mispredictE=1, redirectPCE=0x104, ctr 10→01;
  - second → mispredictE=0, ctr 01→00;
  - then PCF=0x100 → predTakenF=0.
- JAL at 0x200 to 0x080: first pass mispredicts with redirectPCE=0x080. Afterwards PCF=0x200 → predTakenF=1, predTargetF=0x080. Then JALR at 0x300 with PCTargetE=0x500, predTakenE=0 → mispredictE=1, and PCF=0x300 still predicts 0.
- Aliasing: taken branch at 0x100 then taken branch at 0x140 (same index for ENTRIES=16) → the 0x140 entry replaces the 0x100 entry; PCF=0x100 → predTakenF=0.
- Stall and counters:
  - stallE=1 with a mispredicting branch → mispredictE=0 and no counter changes; on release → mispredictE=1 and both counters +1.
  - Force mispredCount to all-ones, then mispredict again → count stays at all-ones.
  - Assert rst mid-stream → all entries invalid, counters 0.
